// File: rtl/dds_step_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dds_step_scheduler_pkg
//  Brief    : Shared types and helpers for the DDS step scheduler: state
//             encodings, step width and the step clamp used by every path
//             that writes the pending addr_step value.
//  Revision : 1.0 - initial release
// ============================================================================
package dds_step_scheduler_pkg;

    localparam int STEP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SWEEP = 2'b01,
        ST_TRACK = 2'b10
    } sched_state_t;

    // Clamp a signed, two-bit-extended step candidate into [lo, hi]
    function automatic logic [STEP_W-1:0] clamp_step(
        input logic signed [STEP_W+1:0] value,
        input logic        [STEP_W-1:0] lo,
        input logic        [STEP_W-1:0] hi
    );
        logic signed [STEP_W+1:0] w_lo;
        logic signed [STEP_W+1:0] w_hi;
        w_lo = $signed({2'b00, lo});
        w_hi = $signed({2'b00, hi});
        if (value < w_lo) begin
            clamp_step = lo;
        end else if (value > w_hi) begin
            clamp_step = hi;
        end else begin
            clamp_step = value[STEP_W-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/dds_step_scheduler_commit.sv
`default_nettype none
// ============================================================================
//  Module   : dds_step_commit
//  Brief    : Wrap-synchronous load register for the DDS addr_step. The
//             pending value is only transferred on a phase-accumulator wrap,
//             so the DDS never sees a step change mid-cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module dds_step_commit
    import dds_step_scheduler_pkg::*;
#(
    parameter logic [STEP_W-1:0] STEP_INIT = 16'd328
) (
    input  logic              clk_60m,
    input  logic              rst_n,
    input  logic [STEP_W-1:0] pend,
    input  logic              dds_wrap,
    output logic [STEP_W-1:0] addr_step,
    output logic              addr_step_load
);

    logic [STEP_W-1:0] r_addr_step;
    logic              r_load;

    // Transfer pend on a wrap only when it differs, flagging the change cycle
    always_ff @(posedge clk_60m or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_step <= STEP_INIT;
            r_load      <= 1'b0;
        end else if (dds_wrap && (pend != r_addr_step)) begin
            r_addr_step <= pend;
            r_load      <= 1'b1;
        end else begin
            r_load      <= 1'b0;
        end
    end

    assign addr_step      = r_addr_step;
    assign addr_step_load = r_load;

endmodule
`default_nettype wire

// File: rtl/dds_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dds_step_scheduler
//  Brief    : Owns the DDS addr_step register. Runs a coarse frequency sweep
//             for acquisition, hands over to fine tracking driven by the
//             phase-lock pulses, detects loss of lock, and arbitrates host,
//             sweep and tracking writes into one pending step that is
//             committed on the next DDS phase wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module dds_step_scheduler
    import dds_step_scheduler_pkg::*;
#(
    parameter logic [STEP_W-1:0] STEP_MIN  = 16'd100,
    parameter logic [STEP_W-1:0] STEP_MAX  = 16'd2000,
    parameter logic [STEP_W-1:0] STEP_INIT = 16'd328,
    parameter int unsigned       DWELL_CYC = 600000,
    parameter int unsigned       ACQ_HITS  = 8,
    parameter int unsigned       LOL_RUN   = 6
) (
    input  logic              clk_60m,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cfg_mode,
    input  logic              cfg_wr,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic              phase_strobe,
    input  logic              phase_in_win,
    input  logic              step_up_pulse,
    input  logic              step_down_pulse,
    input  logic              dds_wrap,
    output logic [STEP_W-1:0] addr_step,
    output logic              addr_step_load,
    output logic [1:0]        state_o,
    output logic              locked,
    output logic [7:0]        sweep_wraps
);

    localparam int c_DWELL_W = $clog2(DWELL_CYC + 1);
    localparam int c_HIT_W   = $clog2(ACQ_HITS + 1);
    localparam int c_RUN_W   = $clog2(LOL_RUN + 1);

    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(DWELL_CYC - 1);
    localparam logic [c_HIT_W-1:0]   c_HIT_LAST   = c_HIT_W'(ACQ_HITS - 1);
    localparam logic [c_RUN_W-1:0]   c_RUN_MAX    = c_RUN_W'(LOL_RUN);

    sched_state_t         r_state;
    logic [STEP_W-1:0]    r_pend;
    logic                 r_locked;
    logic [7:0]           r_sweep_wraps;
    logic [c_DWELL_W-1:0] r_dwell;
    logic [c_HIT_W-1:0]   r_hit;
    logic [c_RUN_W-1:0]   r_run;
    logic                 r_dir_up;

    logic                 w_up;
    logic                 w_dn;
    logic [STEP_W-1:0]    w_cfg_clamped;
    logic [STEP_W-1:0]    w_sweep_next;
    logic [STEP_W-1:0]    w_track_next;
    logic [c_RUN_W-1:0]   w_run_next;
    logic signed [STEP_W+1:0] w_pend_inc;
    logic signed [STEP_W+1:0] w_pend_dec;

    // Next-value candidates for each requester of the pending step
    always_comb begin
        w_up          = step_up_pulse & ~step_down_pulse;
        w_dn          = step_down_pulse & ~step_up_pulse;
        w_pend_inc    = $signed({2'b00, r_pend}) + 18'sd1;
        w_pend_dec    = $signed({2'b00, r_pend}) - 18'sd1;
        w_cfg_clamped = clamp_step($signed({2'b00, cfg_step}), STEP_MIN, STEP_MAX);
        w_sweep_next  = (r_pend >= STEP_MAX) ? STEP_MIN
                                             : clamp_step(w_pend_inc, STEP_MIN, STEP_MAX);
        w_track_next  = w_up ? clamp_step(w_pend_inc, STEP_MIN, STEP_MAX)
                             : clamp_step(w_pend_dec, STEP_MIN, STEP_MAX);
        // A pulse continuing the previous direction extends the run, else restarts it
        if ((r_run != '0) && (r_dir_up == w_up)) begin
            w_run_next = (r_run == c_RUN_MAX) ? c_RUN_MAX : r_run + 1'b1;
        end else begin
            w_run_next = c_RUN_W'(1);
        end
    end

    // Scheduler FSM: host write wins, then enable gating, then per-state work
    always_ff @(posedge clk_60m or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pend        <= STEP_INIT;
            r_locked      <= 1'b0;
            r_sweep_wraps <= 8'd0;
            r_dwell       <= '0;
            r_hit         <= '0;
            r_run         <= '0;
            r_dir_up      <= 1'b0;
        end else if (cfg_wr) begin
            r_pend   <= w_cfg_clamped;
            r_dwell  <= '0;
            r_hit    <= '0;
            r_run    <= '0;
            r_state  <= enable ? ST_TRACK : ST_IDLE;
            r_locked <= enable;
        end else if (!enable) begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_dwell <= '0;
                    r_hit   <= '0;
                    r_run   <= '0;
                    if (cfg_mode) begin
                        r_state  <= ST_SWEEP;
                        r_pend   <= STEP_MIN;
                        r_locked <= 1'b0;
                    end else begin
                        r_state  <= ST_TRACK;
                        r_locked <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (r_dwell == c_DWELL_LAST) begin
                        r_dwell <= '0;
                        r_pend  <= w_sweep_next;
                        if ((r_pend >= STEP_MAX) && (r_sweep_wraps != 8'hFF)) begin
                            r_sweep_wraps <= r_sweep_wraps + 8'd1;
                        end
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                    if (phase_strobe) begin
                        if (!phase_in_win) begin
                            r_hit <= '0;
                        end else if (r_hit == c_HIT_LAST) begin
                            r_hit    <= '0;
                            r_run    <= '0;
                            r_state  <= ST_TRACK;
                            r_locked <= 1'b1;
                        end else begin
                            r_hit <= r_hit + 1'b1;
                        end
                    end
                end
                ST_TRACK: begin
                    if (w_up || w_dn) begin
                        r_pend   <= w_track_next;
                        r_dir_up <= w_up;
                        if (w_run_next == c_RUN_MAX) begin
                            // Sustained one-sided correction: lock is lost
                            r_locked <= 1'b0;
                            if (cfg_mode) begin
                                r_state <= ST_SWEEP;
                                r_run   <= '0;
                                r_hit   <= '0;
                                r_dwell <= '0;
                            end else begin
                                r_run <= w_run_next;
                            end
                        end else begin
                            r_run    <= w_run_next;
                            r_locked <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    dds_step_commit #(
        .STEP_INIT (STEP_INIT)
    ) u_commit (
        .clk_60m        (clk_60m),
        .rst_n          (rst_n),
        .pend           (r_pend),
        .dds_wrap       (dds_wrap),
        .addr_step      (addr_step),
        .addr_step_load (addr_step_load)
    );

    assign state_o     = r_state;
    assign locked      = r_locked;
    assign sweep_wraps = r_sweep_wraps;

endmodule
`default_nettype wire

// File: tb/tb_dds_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dds_step_scheduler
//  Brief    : Self-checking bench for dds_step_scheduler with a short sweep
//             dwell. Directed scenarios followed by random traffic, all
//             compared against a behavioural model of the scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dds_step_scheduler;

    localparam int DWELL  = 4;
    localparam int S_MIN  = 100;
    localparam int S_MAX  = 2000;
    localparam int S_INIT = 328;
    localparam int ACQ    = 8;
    localparam int LOL    = 6;
    localparam int IDLE = 0, SWEEP = 1, TRACK = 2;

    logic        clk_60m = 1'b0;
    logic        rst_n;
    logic        enable, cfg_mode, cfg_wr;
    logic [15:0] cfg_step;
    logic        phase_strobe, phase_in_win;
    logic        step_up_pulse, step_down_pulse, dds_wrap;
    logic [15:0] addr_step;
    logic        addr_step_load;
    logic [1:0]  state_o;
    logic        locked;
    logic [7:0]  sweep_wraps;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    int m_addr, m_pend, m_load, m_state, m_locked, m_wraps;
    int m_dwell, m_hit, m_run, m_dir;

    always #8 clk_60m = ~clk_60m;

    dds_step_scheduler #(
        .DWELL_CYC (DWELL)
    ) dut (
        .clk_60m         (clk_60m),
        .rst_n           (rst_n),
        .enable          (enable),
        .cfg_mode        (cfg_mode),
        .cfg_wr          (cfg_wr),
        .cfg_step        (cfg_step),
        .phase_strobe    (phase_strobe),
        .phase_in_win    (phase_in_win),
        .step_up_pulse   (step_up_pulse),
        .step_down_pulse (step_down_pulse),
        .dds_wrap        (dds_wrap),
        .addr_step       (addr_step),
        .addr_step_load  (addr_step_load),
        .state_o         (state_o),
        .locked          (locked),
        .sweep_wraps     (sweep_wraps)
    );

    function automatic int clampi(input int v);
        return (v < S_MIN) ? S_MIN : ((v > S_MAX) ? S_MAX : v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = S_INIT; m_pend = S_INIT; m_load = 0; m_state = IDLE; m_locked = 0;
        m_wraps = 0; m_dwell = 0; m_hit = 0; m_run = 0; m_dir = 0;
    endtask

    task automatic clear_pulses();
        cfg_wr = 0; phase_strobe = 0; phase_in_win = 0;
        step_up_pulse = 0; step_down_pulse = 0; dds_wrap = 0;
    endtask

    // One clock: advance the model from the sampled inputs, then compare outputs
    task automatic tick();
        int n_addr, n_pend, n_load, n_state, n_locked, n_wraps;
        int n_dwell, n_hit, n_run, n_dir, d;
        @(posedge clk_60m);
        if (!rst_n) begin
            model_reset();
        end else begin
            n_addr = m_addr; n_load = 0;
            if (dds_wrap && (m_pend != m_addr)) begin
                n_addr = m_pend; n_load = 1;
            end
            n_pend = m_pend; n_state = m_state; n_locked = m_locked; n_wraps = m_wraps;
            n_dwell = m_dwell; n_hit = m_hit; n_run = m_run; n_dir = m_dir;
            if (cfg_wr) begin
                n_pend = clampi(int'(cfg_step));
                n_dwell = 0; n_hit = 0; n_run = 0;
                n_state = enable ? TRACK : IDLE;
                n_locked = enable ? 1 : 0;
            end else if (!enable) begin
                n_state = IDLE; n_locked = 0;
            end else if (m_state == IDLE) begin
                n_dwell = 0; n_hit = 0; n_run = 0;
                if (cfg_mode) begin
                    n_state = SWEEP; n_pend = S_MIN; n_locked = 0;
                end else begin
                    n_state = TRACK; n_locked = 1;
                end
            end else if (m_state == SWEEP) begin
                n_dwell = m_dwell + 1;
                if (n_dwell == DWELL) begin
                    n_dwell = 0;
                    if (m_pend == S_MAX) begin
                        n_pend = S_MIN;
                        n_wraps = (m_wraps < 255) ? m_wraps + 1 : 255;
                    end else begin
                        n_pend = m_pend + 1;
                    end
                end
                if (phase_strobe) begin
                    n_hit = phase_in_win ? m_hit + 1 : 0;
                    if (n_hit == ACQ) begin
                        n_state = TRACK; n_locked = 1; n_run = 0; n_hit = 0;
                    end
                end
            end else begin
                d = int'(step_up_pulse) - int'(step_down_pulse);
                if (d != 0) begin
                    n_pend = clampi(m_pend + d);
                    n_run = (m_run > 0 && d == m_dir) ? ((m_run + 1 > LOL) ? LOL : m_run + 1) : 1;
                    n_dir = d;
                    if (n_run == LOL) begin
                        n_locked = 0;
                        if (cfg_mode) begin
                            n_state = SWEEP; n_run = 0; n_hit = 0; n_dwell = 0;
                        end
                    end else begin
                        n_locked = 1;
                    end
                end
            end
            m_addr = n_addr; m_pend = n_pend; m_load = n_load; m_state = n_state;
            m_locked = n_locked; m_wraps = n_wraps; m_dwell = n_dwell; m_hit = n_hit;
            m_run = n_run; m_dir = n_dir;
        end
        #1;
        chk("addr_step", addr_step, m_addr);
        chk("addr_step_load", addr_step_load, m_load);
        chk("state_o", state_o, m_state);
        chk("locked", locked, m_locked);
        chk("sweep_wraps", sweep_wraps, m_wraps);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int base;
    int loads;

    initial begin
        rst_n = 0; enable = 0; cfg_mode = 0; cfg_step = 16'd0;
        clear_pulses();
        model_reset();
        ticks(3);
        rst_n = 1;

        // 1: reset values, no wrap
        ticks(5);
        chk("t1_addr", addr_step, 328);
        chk("t1_load", addr_step_load, 0);
        chk("t1_state", state_o, 0);
        chk("t1_locked", locked, 0);

        // 2: sweep, commits only on wraps, pass wrap at 2000
        enable = 1; cfg_mode = 1;
        tick();
        chk("t2_sweep", state_o, 1);
        ticks(40);
        chk("t2_no_commit", addr_step, 328);
        dds_wrap = 1; tick(); dds_wrap = 0;
        chk("t2_commit_110", addr_step, 110);
        chk("t2_load", addr_step_load, 1);
        tick();
        chk("t2_load_drop", addr_step_load, 0);
        ticks(7559);
        dds_wrap = 1; tick(); dds_wrap = 0;
        chk("t2_commit_2000", addr_step, 2000);
        tick();
        chk("t2_wraps0", sweep_wraps, 0);
        tick();
        chk("t2_wraps1", sweep_wraps, 1);
        dds_wrap = 1; tick(); dds_wrap = 0;
        chk("t2_commit_100", addr_step, 100);

        // 3: acquisition, out-of-window strobe restarts the hit count
        for (int i = 0; i < 6; i++) begin
            phase_strobe = 1; phase_in_win = 1; tick(); clear_pulses(); tick();
        end
        phase_strobe = 1; phase_in_win = 0; tick(); clear_pulses(); tick();
        for (int i = 0; i < 7; i++) begin
            phase_strobe = 1; phase_in_win = 1; tick(); clear_pulses(); tick();
        end
        chk("t3_still_sweep", state_o, 1);
        phase_strobe = 1; phase_in_win = 1; tick(); clear_pulses();
        chk("t3_track", state_o, 2);
        chk("t3_locked", locked, 1);

        // 4: up, up, down, up+down -> net +1, one load
        dds_wrap = 1; tick(); dds_wrap = 0; tick();
        base = m_pend;
        chk("t4_synced", addr_step, base);
        step_up_pulse = 1; tick(); tick(); clear_pulses();
        step_down_pulse = 1; tick(); clear_pulses();
        step_up_pulse = 1; step_down_pulse = 1; tick(); clear_pulses();
        loads = 0;
        dds_wrap = 1; tick(); dds_wrap = 0; loads += addr_step_load;
        chk("t4_net_plus1", addr_step, base + 1);
        tick(); loads += addr_step_load;
        dds_wrap = 1; tick(); dds_wrap = 0; loads += addr_step_load;
        tick(); loads += addr_step_load;
        chk("t4_single_load", loads, 1);

        // 5: six ups with auto mode -> back to sweep
        for (int i = 0; i < 5; i++) begin
            step_up_pulse = 1; tick(); clear_pulses(); tick();
        end
        chk("t5_still_locked", locked, 1);
        step_up_pulse = 1; tick(); clear_pulses();
        chk("t5_lol_sweep", state_o, 1);
        chk("t5_lol_unlocked", locked, 0);
        // track-only mode: six ups stay in track
        cfg_wr = 1; cfg_step = 16'd1000; tick(); clear_pulses();
        chk("t5_cfg_track", state_o, 2);
        cfg_mode = 0;
        for (int i = 0; i < 6; i++) begin
            step_up_pulse = 1; tick(); clear_pulses();
        end
        chk("t5_stay_track", state_o, 2);
        dds_wrap = 1; tick(); dds_wrap = 0;
        chk("t5_plus6", addr_step, 1006);

        // 6: host write wins over step_up, clamps, commits on the following wrap
        cfg_wr = 1; cfg_step = 16'd5000; step_up_pulse = 1; dds_wrap = 1;
        tick(); clear_pulses();
        chk("t6_same_wrap", addr_step, 1006);
        chk("t6_no_load", addr_step_load, 0);
        tick();
        dds_wrap = 1; tick(); dds_wrap = 0;
        chk("t6_commit_2000", addr_step, 2000);
        chk("t6_load", addr_step_load, 1);
        // saturation at the top, then a pending commit survives disable
        step_up_pulse = 1; tick(); clear_pulses();
        dds_wrap = 1; tick(); dds_wrap = 0;
        chk("t6_sat_no_load", addr_step_load, 0);
        step_down_pulse = 1; tick(); clear_pulses();
        enable = 0; tick();
        chk("t7_idle", state_o, 0);
        chk("t7_unlocked", locked, 0);
        dds_wrap = 1; tick(); dds_wrap = 0;
        chk("t7_pending_commit", addr_step, 1999);

        // reset in the middle of a sweep
        enable = 1; cfg_mode = 1; ticks(10);
        chk("t8_sweeping", state_o, 1);
        #3 rst_n = 0;
        #1;
        model_reset();
        chk("t8_rst_addr", addr_step, 328);
        chk("t8_rst_state", state_o, 0);
        chk("t8_rst_wraps", sweep_wraps, 0);
        tick();
        rst_n = 1;

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            enable          = ($urandom_range(0, 99) < 95);
            if ($urandom_range(0, 199) == 0) cfg_mode = ~cfg_mode;
            cfg_wr          = ($urandom_range(0, 199) == 0);
            cfg_step        = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2600));
            phase_strobe    = ($urandom_range(0, 3) == 0);
            phase_in_win    = ($urandom_range(0, 9) < 8);
            step_up_pulse   = ($urandom_range(0, 5) == 0);
            step_down_pulse = ($urandom_range(0, 5) == 0);
            dds_wrap        = ($urandom_range(0, 7) == 0);
            tick();
        end
        clear_pulses();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
